// File: rtl/run_controller.sv
// Run/halt controller for the pipelined core: sequences core reset, gates execution
// (free-run or single-step), counts executed cycles, detects halt and watchdog timeout.
module run_controller #(
   parameter int unsigned                OP_WIDTH     = 6,
   parameter logic [OP_WIDTH-1:0]        HALT_OP      = 6'b111111,
   parameter int unsigned                CNT_WIDTH    = 32,
   parameter int unsigned                RESET_CYCLES = 4,
   parameter int unsigned                TIMEOUT      = 0
) (
   input  logic                 sysclk,
   input  logic                 rstd,
   input  logic                 start,
   input  logic                 step_mode,
   input  logic                 step,
   input  logic [OP_WIDTH-1:0]  op,
   output logic                 core_rst,
   output logic                 core_en,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 running,
   output logic                 halted,
   output logic                 timed_out,
   output logic                 done
);

   localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
   localparam bit WdogEn = (TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0] WdogLast = CNT_WIDTH'(TIMEOUT - 1);

   typedef enum logic [1:0] {StSeq, StRun, StHalt, StTimeout} state_e;

   state_e               state_q, state_d;
   logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 done_q, done_d;

   always_ff @(posedge sysclk or posedge rstd) begin
      if (rstd) begin
         state_q   <= StSeq;
         rst_cnt_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         count_q   <= count_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      count_d   = count_q;
      done_d    = 1'b0;
      core_rst  = 1'b0;
      core_en   = 1'b0;
      running   = 1'b0;
      halted    = 1'b0;
      timed_out = 1'b0;
      unique case (state_q)
         StSeq: begin
            core_rst = 1'b1;
            if (rst_cnt_q == RstLast) begin
               rst_cnt_d = '0;
               state_d   = StRun;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         StRun: begin
            running = 1'b1;
            core_en = ~step_mode | step;
            if (core_en) begin
               count_d = count_q + 1'b1;
               // Halt wins over the watchdog when both fire on the same cycle.
               if (op == HALT_OP) begin
                  state_d = StHalt;
                  done_d  = 1'b1;
               end else if (WdogEn && (count_q == WdogLast)) begin
                  state_d = StTimeout;
                  done_d  = 1'b1;
               end
            end
         end
         StHalt, StTimeout: begin
            halted    = (state_q == StHalt);
            timed_out = (state_q == StTimeout);
            if (start) begin
               state_d   = StSeq;
               count_d   = '0;
               rst_cnt_d = '0;
            end
         end
         default: state_d = StSeq;
      endcase
   end

   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: expected output snapshots are queued as each
// step is driven and popped for comparison once the DUT has responded.
module tb_run_controller;

   logic        sysclk = 1'b0;
   logic        rstd, start, step_mode, step;
   logic [5:0]  op;
   logic        core_rst, core_en, running, halted, timed_out, done;
   logic [31:0] count;

   run_controller #(
      .OP_WIDTH     (6),
      .HALT_OP      (6'h3F),
      .CNT_WIDTH    (32),
      .RESET_CYCLES (4),
      .TIMEOUT      (16)
   ) dut (
      .sysclk    (sysclk),
      .rstd      (rstd),
      .start     (start),
      .step_mode (step_mode),
      .step      (step),
      .op        (op),
      .core_rst  (core_rst),
      .core_en   (core_en),
      .count     (count),
      .running   (running),
      .halted    (halted),
      .timed_out (timed_out),
      .done      (done)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      string       tag;
      logic [37:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [37:0] obs;

   // Snapshot layout: {core_rst, core_en, running, halted, timed_out, done, count}
   assign obs = {core_rst, core_en, running, halted, timed_out, done, count};

   function automatic logic [37:0] mk(bit r, bit e, bit ru, bit h, bit t, bit d,
                                      int unsigned c);
      return {r, e, ru, h, t, d, c};
   endfunction

   task automatic compare();
      exp_t x;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL sb_underflow observed=%h expected=queued_entry", obs);
         return;
      end
      x = sb.pop_front();
      assert (obs === x.exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
   endtask

   task automatic cyc(string tag, logic [37:0] e);
      sb.push_back('{tag, e});
      @(posedge sysclk);
      #1;
      compare();
   endtask

   task automatic now(string tag, logic [37:0] e);
      sb.push_back('{tag, e});
      compare();
   endtask

   // From HALT/TIMEOUT: start edge enters SEQ, three more SEQ edges, then RUN.
   task automatic restart(bit en);
      start = 1'b1;
      cyc("restart", mk(1, 0, 0, 0, 0, 0, 0));
      start = 1'b0;
      for (int i = 0; i < 3; i++) cyc("restart_seq", mk(1, 0, 0, 0, 0, 0, 0));
      cyc("restart_run", mk(0, en, 1, 0, 0, 0, 0));
   endtask

   initial begin
      rstd = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; op = '0;
      repeat (2) @(posedge sysclk);
      #1;
      now("reset", mk(1, 0, 0, 0, 0, 0, 0));
      rstd = 1'b0;
      for (int i = 0; i < 3; i++) cyc("seq", mk(1, 0, 0, 0, 0, 0, 0));
      cyc("run_entry", mk(0, 1, 1, 0, 0, 0, 0));

      // Free-run halt at the tenth executed cycle.
      for (int i = 1; i <= 9; i++) cyc($sformatf("run%0d", i), mk(0, 1, 1, 0, 0, 0, i));
      op = 6'h3F;
      cyc("halt", mk(0, 0, 0, 1, 0, 1, 10));
      op = '0;
      for (int i = 0; i < 20; i++) cyc("halt_hold", mk(0, 0, 0, 1, 0, 0, 10));

      restart(1'b1);
      start = 1'b1;
      cyc("start_in_run", mk(0, 1, 1, 0, 0, 0, 1));
      start = 1'b0;

      // Watchdog with TIMEOUT=16.
      for (int i = 2; i <= 15; i++) cyc($sformatf("wd_run%0d", i), mk(0, 1, 1, 0, 0, 0, i));
      cyc("timeout", mk(0, 0, 0, 0, 1, 1, 16));
      cyc("timeout_hold", mk(0, 0, 0, 0, 1, 0, 16));

      // Halt opcode on the 16th executed cycle beats the watchdog.
      restart(1'b1);
      for (int i = 1; i <= 15; i++) cyc($sformatf("wdh_run%0d", i), mk(0, 1, 1, 0, 0, 0, i));
      op = 6'h3F;
      cyc("wd_halt", mk(0, 0, 0, 1, 0, 1, 16));
      op = '0;

      // Single step.
      step_mode = 1'b1;
      restart(1'b0);
      for (int k = 1; k <= 3; k++) begin
         step = 1'b1;
         cyc($sformatf("step%0d", k), mk(0, 1, 1, 0, 0, 0, k));
         step = 1'b0;
         for (int i = 0; i < 5; i++) cyc("step_idle", mk(0, 0, 1, 0, 0, 0, k));
      end
      op = 6'h3F;
      for (int i = 0; i < 5; i++) cyc("stall_halt_op", mk(0, 0, 1, 0, 0, 0, 3));
      step = 1'b1;
      cyc("step_halt", mk(0, 0, 0, 1, 0, 1, 4));
      step = 1'b0;
      op = '0;

      // Async reset between edges at count=7.
      step_mode = 1'b0;
      restart(1'b1);
      for (int i = 1; i <= 7; i++) cyc($sformatf("ar_run%0d", i), mk(0, 1, 1, 0, 0, 0, i));
      #2;
      rstd = 1'b1;
      #1;
      now("async_reset", mk(1, 0, 0, 0, 0, 0, 0));
      #2;
      rstd = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ar_seq", mk(1, 0, 0, 0, 0, 0, 0));
      cyc("ar_run_entry", mk(0, 1, 1, 0, 0, 0, 0));
      cyc("ar_run1", mk(0, 1, 1, 0, 0, 0, 1));

      // Step held high executes one cycle per high cycle.
      step_mode = 1'b1;
      step = 1'b1;
      for (int i = 2; i <= 4; i++) cyc($sformatf("step_held%0d", i), mk(0, 1, 1, 0, 0, 0, i));
      step = 1'b0;
      cyc("step_released", mk(0, 0, 1, 0, 0, 0, 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
